imm_extend_pipe: RTL

- Registered immediate/target extension stage between decode and execute.
- Extracts the immediate or jump-target field from an instruction, sign- or zero-extends it to XLEN, and forwards it with the instruction over a valid/ready pipeline interface.
- A 2-entry skid buffer lets in_ready be driven from a register.
- A saturating counter records output back-pressure cycles.

---
 rtl/imm_extend_pipe.sv | 115 +++++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// Decode-to-execute immediate/target extension stage with a 2-entry skid buffer.
// Results are extended at capture and presented from the main register; stalls are counted.
module imm_extend_pipe #(
    parameter int XLEN    = 32,
    parameter int OPW     = 5,
    parameter int IMM_W   = 17,
    parameter int TGT_W   = 27,
    parameter int TGT_OP0 = 1,
    parameter int TGT_OP1 = 21,
    parameter int TGT_OP2 = 22,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_ir,
    input  logic             in_zext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_ir,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_is_tgt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] imm;
        logic            tgt;
    } entry_t;

    logic [OPW-1:0]  w_op;
    logic            w_is_tgt;
    logic [XLEN-1:0] w_tgt_ext, w_imm_sext, w_imm_zext;
    entry_t          w_new;
    logic            w_accept, w_drain;

    entry_t          r_main, r_skid;
    logic            r_main_vld, r_skid_vld;
    logic [CNT_W-1:0] r_stall;

    assign w_op     = in_ir[XLEN-1 -: OPW];
    assign w_is_tgt = (w_op == OPW'(TGT_OP0)) || (w_op == OPW'(TGT_OP1)) ||
                      (w_op == OPW'(TGT_OP2));

    // Fields as wide as the datapath are passed through unextended.
    generate
        if (TGT_W >= XLEN) begin : g_tgt_full
            assign w_tgt_ext = in_ir[XLEN-1:0];
        end else begin : g_tgt_ext
            assign w_tgt_ext = {{(XLEN-TGT_W){in_ir[TGT_W-1]}}, in_ir[TGT_W-1:0]};
        end
        if (IMM_W >= XLEN) begin : g_imm_full
            assign w_imm_sext = in_ir[XLEN-1:0];
            assign w_imm_zext = in_ir[XLEN-1:0];
        end else begin : g_imm_ext
            assign w_imm_sext = {{(XLEN-IMM_W){in_ir[IMM_W-1]}}, in_ir[IMM_W-1:0]};
            assign w_imm_zext = {{(XLEN-IMM_W){1'b0}}, in_ir[IMM_W-1:0]};
        end
    endgenerate

    assign w_new.ir  = in_ir;
    assign w_new.imm = w_is_tgt ? w_tgt_ext : (in_zext ? w_imm_zext : w_imm_sext);
    assign w_new.tgt = w_is_tgt;

    assign in_ready = !r_skid_vld;
    assign w_accept = in_valid && !r_skid_vld;
    assign w_drain  = r_main_vld && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (flush) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (w_drain) begin
            // A full skid blocks accept, so refill from skid takes priority.
            if (r_skid_vld) begin
                r_main     <= r_skid;
                r_skid_vld <= 1'b0;
            end else if (w_accept) begin
                r_main     <= w_new;
            end else begin
                r_main_vld <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_vld) begin
                r_main     <= w_new;
                r_main_vld <= 1'b1;
            end else begin
                r_skid     <= w_new;
                r_skid_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_stall <= '0;
        else if (r_main_vld && !out_ready && !flush && (r_stall != {CNT_W{1'b1}}))
            r_stall <= r_stall + 1'b1;
    end

    assign out_valid  = r_main_vld;
    assign out_ir     = r_main.ir;
    assign out_imm    = r_main.imm;
    assign out_is_tgt = r_main.tgt;
    assign stall_cnt  = r_stall;

endmodule
